axi_slave_mem_model: RTL and testbench

//  Parametrised AXI4 slave memory: next-generation, synthesizable replacement for the sim-only slave BFM on the core's bus.

---
 rtl/axi_slave_mem_model_if.sv | 46 ++++
 rtl/axi_slave_mem_model.sv | 228 ++++++++++++++++++++++
 tb/tb_axi_slave_mem_model.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_mem_model_if.sv
// AXI4 bus bundle between the MMU (master) and the slave memory model.
// Handshake rule on every channel: a transfer happens on the rising CLK edge
// where xVALID and xREADY are both 1. The source holds xVALID and its payload
// stable until that edge; xREADY may be asserted before xVALID arrives.
interface axi_slave_mem_model_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport slave (
    input  AWADDR, AWLEN, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  ARADDR, ARLEN, ARBURST, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID
  );

  modport master (
    output AWADDR, AWLEN, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    output ARADDR, ARLEN, ARBURST, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_slave_mem_model.sv
// Synthesizable AXI4 slave memory. Independent read and write engines, one
// outstanding burst each, INCR/WRAP bursts, byte strobes, programmable
// latency and SLVERR for illegal bursts or beats outside the memory.
module axi_slave_mem_model #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 14,
  parameter int RD_LAT     = 2,
  parameter int WR_LAT     = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  axi_slave_mem_model_if.slave   s_axi,
  output logic [1:0]             o_wr_state,
  output logic [1:0]             o_rd_state
);
  localparam int STRB_W = DATA_W / 8;
  localparam int SB     = $clog2(STRB_W);
  localparam int WORDS  = 1 << DEPTH_LOG2;
  localparam logic [63:0] MEM_BYTES = 64'(STRB_W) << DEPTH_LOG2;
  localparam logic [63:0] ADDR_SPAN = 64'd1 << ADDR_W;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_LAT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_t;

  // Start addresses are aligned down to the bus width.
  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    align = a & ~ADDR_W'(STRB_W - 1);
  endfunction

  // Address of the following beat; WRAP keeps the upper bits of the window.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [7:0] len,
                                                  input logic [1:0] burst);
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] inc;
    mask = ADDR_W'(({24'd0, len} + 32'd1) * STRB_W - 32'd1);
    inc  = a + ADDR_W'(STRB_W);
    if (burst == BURST_WRAP) next_addr = (a & ~mask) | (inc & mask);
    else                     next_addr = inc;
  endfunction

  // Whole-burst error decision from the aligned start address; only the
  // highest beat address of the burst can leave the memory range.
  function automatic logic burst_err(input logic [ADDR_W-1:0] a,
                                     input logic [7:0] len,
                                     input logic [1:0] burst);
    logic [63:0] first;
    logic [63:0] span;
    logic [63:0] last;
    first     = 64'(a);
    span      = 64'(len) * 64'(STRB_W);
    last      = first + span;
    burst_err = 1'b0;
    if (burst != BURST_INCR && burst != BURST_WRAP) begin
      burst_err = 1'b1;
    end else if (burst == BURST_WRAP) begin
      if (len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15) begin
        burst_err = 1'b1;
      end else begin
        first = first & ~(span + 64'(STRB_W) - 64'd1);
        last  = first + span;
        if (last >= MEM_BYTES) burst_err = 1'b1;
      end
    end else if (MEM_BYTES < ADDR_SPAN && last >= MEM_BYTES) begin
      burst_err = 1'b1;
    end
  endfunction

  logic [DATA_W-1:0] r_mem [WORDS];

  w_state_t          r_w_state;
  logic [ADDR_W-1:0] r_w_addr;
  logic [7:0]        r_w_len;
  logic [7:0]        r_w_beat;
  logic [1:0]        r_w_burst;
  logic              r_w_err;
  logic              r_w_last_err;
  logic [15:0]       r_w_cnt;

  r_state_t          r_r_state;
  logic [ADDR_W-1:0] r_r_addr;
  logic [7:0]        r_r_len;
  logic [7:0]        r_r_beat;
  logic [1:0]        r_r_burst;
  logic              r_r_err;
  logic [15:0]       r_r_cnt;

  logic [ADDR_W-1:0] w_aw_start;
  logic [ADDR_W-1:0] w_ar_start;
  logic [ADDR_W-1:0] w_r_next;
  logic              w_w_fire;
  logic              w_w_last_beat;

  assign w_aw_start    = align(s_axi.AWADDR);
  assign w_ar_start    = align(s_axi.ARADDR);
  assign w_r_next      = next_addr(r_r_addr, r_r_len, r_r_burst);
  assign w_w_fire      = (r_w_state == W_DATA) && s_axi.WVALID;
  assign w_w_last_beat = (r_w_beat == r_w_len);
  assign o_wr_state    = r_w_state;
  assign o_rd_state    = r_r_state;

  // Byte-lane write of each accepted beat; contents survive reset.
  always_ff @(posedge CLK) begin
    if (w_w_fire && !r_w_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.WSTRB[b]) r_mem[r_w_addr[SB +: DEPTH_LOG2]][b*8 +: 8] <= s_axi.WDATA[b*8 +: 8];
      end
    end
  end

  // Write engine: accept AW, consume exactly AWLEN+1 beats, wait, respond.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_w_state     <= W_IDLE;
      r_w_addr      <= '0;
      r_w_len       <= '0;
      r_w_beat      <= '0;
      r_w_burst     <= '0;
      r_w_err       <= 1'b0;
      r_w_last_err  <= 1'b0;
      r_w_cnt       <= '0;
      s_axi.AWREADY <= 1'b1;
      s_axi.WREADY  <= 1'b0;
      s_axi.BVALID  <= 1'b0;
      s_axi.BRESP   <= RESP_OKAY;
    end else begin
      case (r_w_state)
        W_IDLE: if (s_axi.AWVALID) begin
          r_w_addr      <= w_aw_start;
          r_w_len       <= s_axi.AWLEN;
          r_w_burst     <= s_axi.AWBURST;
          r_w_err       <= burst_err(w_aw_start, s_axi.AWLEN, s_axi.AWBURST);
          r_w_last_err  <= 1'b0;
          r_w_beat      <= '0;
          s_axi.AWREADY <= 1'b0;
          s_axi.WREADY  <= 1'b1;
          r_w_state     <= W_DATA;
        end
        W_DATA: if (s_axi.WVALID) begin
          if (s_axi.WLAST != w_w_last_beat) r_w_last_err <= 1'b1;
          if (w_w_last_beat) begin
            s_axi.WREADY <= 1'b0;
            r_w_cnt      <= 16'(WR_LAT - 1);
            r_w_state    <= W_LAT;
          end else begin
            r_w_beat <= r_w_beat + 8'd1;
            r_w_addr <= next_addr(r_w_addr, r_w_len, r_w_burst);
          end
        end
        W_LAT: if (r_w_cnt == 16'd0) begin
          s_axi.BVALID <= 1'b1;
          s_axi.BRESP  <= (r_w_err || r_w_last_err) ? RESP_SLVERR : RESP_OKAY;
          r_w_state    <= W_RESP;
        end else begin
          r_w_cnt <= r_w_cnt - 16'd1;
        end
        W_RESP: if (s_axi.BREADY) begin
          s_axi.BVALID  <= 1'b0;
          s_axi.BRESP   <= RESP_OKAY;
          s_axi.AWREADY <= 1'b1;
          r_w_state     <= W_IDLE;
        end
        default: r_w_state <= W_IDLE;
      endcase
    end
  end

  // Read engine: accept AR, wait RD_LAT, stream beats; outputs only move on RREADY.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_r_state     <= R_IDLE;
      r_r_addr      <= '0;
      r_r_len       <= '0;
      r_r_beat      <= '0;
      r_r_burst     <= '0;
      r_r_err       <= 1'b0;
      r_r_cnt       <= '0;
      s_axi.ARREADY <= 1'b1;
      s_axi.RVALID  <= 1'b0;
      s_axi.RDATA   <= '0;
      s_axi.RRESP   <= RESP_OKAY;
      s_axi.RLAST   <= 1'b0;
    end else begin
      case (r_r_state)
        R_IDLE: if (s_axi.ARVALID) begin
          r_r_addr      <= w_ar_start;
          r_r_len       <= s_axi.ARLEN;
          r_r_burst     <= s_axi.ARBURST;
          r_r_err       <= burst_err(w_ar_start, s_axi.ARLEN, s_axi.ARBURST);
          r_r_beat      <= '0;
          r_r_cnt       <= 16'(RD_LAT - 1);
          s_axi.ARREADY <= 1'b0;
          r_r_state     <= R_LAT;
        end
        R_LAT: if (r_r_cnt == 16'd0) begin
          s_axi.RVALID <= 1'b1;
          s_axi.RDATA  <= r_r_err ? '0 : r_mem[r_r_addr[SB +: DEPTH_LOG2]];
          s_axi.RRESP  <= r_r_err ? RESP_SLVERR : RESP_OKAY;
          s_axi.RLAST  <= (r_r_len == 8'd0);
          r_r_state    <= R_DATA;
        end else begin
          r_r_cnt <= r_r_cnt - 16'd1;
        end
        R_DATA: if (s_axi.RREADY) begin
          if (s_axi.RLAST) begin
            s_axi.RVALID  <= 1'b0;
            s_axi.RLAST   <= 1'b0;
            s_axi.RDATA   <= '0;
            s_axi.RRESP   <= RESP_OKAY;
            s_axi.ARREADY <= 1'b1;
            r_r_state     <= R_IDLE;
          end else begin
            r_r_addr    <= w_r_next;
            r_r_beat    <= r_r_beat + 8'd1;
            s_axi.RDATA <= r_r_err ? '0 : r_mem[w_r_next[SB +: DEPTH_LOG2]];
            s_axi.RLAST <= ((r_r_beat + 8'd1) == r_r_len);
          end
        end
        default: r_r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_slave_mem_model.sv
// Self-checking bench for axi_slave_mem_model: reset values, a directed
// vector table, multi-cycle corner sequences and a randomized phase
// checked against a word-array reference model.
module tb_axi_slave_mem_model;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int DEPTH_LOG2 = 14;
  localparam int RD_LAT     = 2;
  localparam int WR_LAT     = 1;
  localparam int STRB_W     = DATA_W / 8;
  localparam longint MEM_BYTES = longint'(STRB_W) << DEPTH_LOG2;
  localparam int TMO        = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] wr_state;
  logic [1:0] rd_state;
  always #5 clk = ~clk;

  axi_slave_mem_model_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  axi_slave_mem_model #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2),
    .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .s_axi(bus.slave),
    .o_wr_state(wr_state),
    .o_rd_state(rd_state)
  );

  // ---------------- bookkeeping ----------------
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  bit  abort = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [int];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    abort = 1'b1;
    $display("FAIL %s: no handshake within %0d cycles, expected one", name, TMO);
  endtask

  // ---------------- reference model ----------------
  function automatic longint beat_addr(input longint a, input int len, input logic [1:0] burst, input int i);
    longint start;
    longint size;
    longint base;
    start = a - (a % STRB_W);
    size  = longint'(len + 1) * STRB_W;
    if (burst == 2'b10) begin
      base = start - (start % size);
      return base + ((start - base) + longint'(i) * STRB_W) % size;
    end
    return (start + longint'(i) * STRB_W) % (longint'(1) << 32);
  endfunction

  function automatic bit model_err(input longint a, input int len, input logic [1:0] burst);
    if (burst == 2'b00 || burst == 2'b11) return 1'b1;
    if (burst == 2'b10 && !(len inside {1, 3, 7, 15})) return 1'b1;
    for (int i = 0; i <= len; i++)
      if (beat_addr(a, len, burst, i) >= MEM_BYTES) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] burst);
    int w;
    logic [31:0] cur;
    if (model_err(longint'(addr), len, burst)) return;
    for (int i = 0; i <= len; i++) begin
      w = int'(beat_addr(longint'(addr), len, burst, i) / STRB_W);
      cur = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
      for (int b = 0; b < STRB_W; b++)
        if (sbuf[i][b]) cur[b*8 +: 8] = wbuf[i][b*8 +: 8];
      ref_mem[w] = cur;
    end
  endtask

  task automatic model_read(input logic [31:0] addr, input int len, input logic [1:0] burst);
    int w;
    bit err;
    err = model_err(longint'(addr), len, burst);
    for (int i = 0; i <= len; i++) begin
      w = int'(beat_addr(longint'(addr), len, burst, i) / STRB_W);
      if (err) exp_q.push_back(32'h0);
      else     exp_q.push_back(ref_mem.exists(w) ? ref_mem[w] : 32'h0);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Beat i uses wbuf[i]/sbuf[i]; bad_last = beat index whose WLAST is inverted (-1: none).
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input int bad_last, output logic [1:0] resp, output int lat);
    int n;
    resp = 2'bxx;
    lat  = -1;
    if (abort) return;
    bus.AWADDR  = addr;
    bus.AWLEN   = len[7:0];
    bus.AWBURST = burst;
    bus.AWVALID = 1'b1;
    n = 0;
    while (!bus.AWREADY && n < TMO) begin step(); n++; end
    if (!bus.AWREADY) begin bus.AWVALID = 1'b0; timeout("aw_ready"); return; end
    step();
    bus.AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.WDATA  = wbuf[i];
      bus.WSTRB  = sbuf[i];
      bus.WLAST  = (i == len) ^ (i == bad_last);
      bus.WVALID = 1'b1;
      n = 0;
      while (!bus.WREADY && n < TMO) begin step(); n++; end
      if (!bus.WREADY) begin bus.WVALID = 1'b0; timeout("w_ready"); return; end
      step();
    end
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
    lat = 0;
    while (!bus.BVALID && lat < TMO) begin step(); lat++; end
    if (!bus.BVALID) begin timeout("b_valid"); return; end
    resp = bus.BRESP;
    step();
  endtask

  // Collects beats into rd_*; RREADY drops for stall_n cycles before beat stall_beat.
  task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input int stall_beat, input int stall_n, output int lat);
    int n;
    int gaps;
    logic [34:0] hold;
    lat  = -1;
    gaps = 0;
    if (abort) return;
    bus.ARADDR  = addr;
    bus.ARLEN   = len[7:0];
    bus.ARBURST = burst;
    bus.ARVALID = 1'b1;
    bus.RREADY  = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < TMO) begin step(); n++; end
    if (!bus.ARREADY) begin bus.ARVALID = 1'b0; timeout("ar_ready"); return; end
    step();
    bus.ARVALID = 1'b0;
    lat = 0;
    while (!bus.RVALID && lat < TMO) begin step(); lat++; end
    if (!bus.RVALID) begin timeout("r_valid"); return; end
    for (int i = 0; i <= len; i++) begin
      n = 0;
      while (!bus.RVALID && n < TMO) begin step(); n++; gaps++; end
      if (!bus.RVALID) begin timeout("r_beat"); return; end
      if (i == stall_beat && stall_n > 0) begin
        bus.RREADY = 1'b0;
        hold = {bus.RDATA, bus.RRESP, bus.RLAST};
        for (int k = 0; k < stall_n; k++) begin
          step();
          chk("r_hold", {bus.RVALID, bus.RDATA, bus.RRESP, bus.RLAST}, {1'b1, hold});
        end
        bus.RREADY = 1'b1;
      end
      rd_data[i] = bus.RDATA;
      rd_resp[i] = bus.RRESP;
      rd_last[i] = bus.RLAST;
      step();
    end
    chk("r_stream_gaps", gaps, 0);
    chk("r_end_valid", bus.RVALID, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit               is_wr;
    logic [31:0]      addr;
    int               len;
    logic [1:0]       burst;
    logic [3:0]       strb;
    logic [31:0]      data0;      // write beat i carries data0 + i
    logic [1:0]       exp_resp;
    logic [3:0]       exp_mask;   // read beats whose data is compared
    logic [3:0][31:0] exp_d;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input bit w, input logic [31:0] a, input int len, input logic [1:0] bu,
                              input logic [3:0] st, input logic [31:0] d0, input logic [1:0] rs,
                              input logic [3:0] m, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    vec_t v;
    v.is_wr = w; v.addr = a; v.len = len; v.burst = bu; v.strb = st; v.data0 = d0;
    v.exp_resp = rs; v.exp_mask = m; v.exp_d = {e3, e2, e1, e0};
    return v;
  endfunction

  initial begin
    logic [1:0] resp;
    int lat;
    vec_t v;
    logic [31:0] addr;
    int len;
    logic [1:0] burst;
    int r;
    bit err;

    bus.AWADDR = '0; bus.AWLEN = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b1;
    bus.ARADDR = '0; bus.ARLEN = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b1;

    vecs[0]  = mk(1, 32'h10,    0, 2'b01, 4'hF, 32'hDEADBEEF, 2'b00, 4'h0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 32'h10,    3, 2'b01, 4'h0, 0,            2'b00, 4'h1, 32'hDEADBEEF, 0, 0, 0);
    vecs[2]  = mk(1, 32'h10,    0, 2'b01, 4'h2, 32'h0000AB00, 2'b00, 4'h0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 32'h10,    0, 2'b01, 4'h0, 0,            2'b00, 4'h1, 32'hDEADABEF, 0, 0, 0);
    vecs[4]  = mk(1, 32'h18,    3, 2'b10, 4'hF, 32'hA0000000, 2'b00, 4'h0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 32'h10,    3, 2'b01, 4'h0, 0,            2'b00, 4'hF,
                  32'hA0000002, 32'hA0000003, 32'hA0000000, 32'hA0000001);
    vecs[6]  = mk(0, 32'h18,    3, 2'b10, 4'h0, 0,            2'b00, 4'hF,
                  32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003);
    vecs[7]  = mk(0, 32'h10000, 1, 2'b01, 4'h0, 0,            2'b10, 4'h3, 0, 0, 0, 0);
    vecs[8]  = mk(1, 32'h10,    0, 2'b00, 4'hF, 32'h12345678, 2'b10, 4'h0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 32'h10,    0, 2'b01, 4'h0, 0,            2'b00, 4'h1, 32'hA0000002, 0, 0, 0);
    vecs[10] = mk(0, 32'h10,    2, 2'b10, 4'h0, 0,            2'b10, 4'h7, 0, 0, 0, 0);
    vecs[11] = mk(1, 32'hFFFC,  0, 2'b01, 4'hF, 32'h5A5A0001, 2'b00, 4'h0, 0, 0, 0, 0);
    vecs[12] = mk(0, 32'hFFFC,  1, 2'b01, 4'h0, 0,            2'b10, 4'h3, 0, 0, 0, 0);
    vecs[13] = mk(0, 32'hFFFD,  0, 2'b01, 4'h0, 0,            2'b00, 4'h1, 32'h5A5A0001, 0, 0, 0);
    vecs[14] = mk(1, 32'hFFF8,  1, 2'b01, 4'hF, 32'hC0000000, 2'b00, 4'h0, 0, 0, 0, 0);
    vecs[15] = mk(1, 32'hFFFC,  1, 2'b01, 4'hF, 32'h99990000, 2'b10, 4'h0, 0, 0, 0, 0);
    vecs[16] = mk(0, 32'hFFF8,  1, 2'b01, 4'h0, 0,            2'b00, 4'h3, 32'hC0000000, 32'hC0000001, 0, 0);
    vecs[17] = mk(1, 32'h20,    2, 2'b10, 4'hF, 32'h0BAD0000, 2'b10, 4'h0, 0, 0, 0, 0);

    // ---- reset values ----
    step(); step();
    chk("rst_awready", bus.AWREADY, 1'b1);
    chk("rst_arready", bus.ARREADY, 1'b1);
    chk("rst_bvalid",  bus.BVALID,  1'b0);
    chk("rst_rvalid",  bus.RVALID,  1'b0);
    chk("rst_wready",  bus.WREADY,  1'b0);
    chk("rst_rlast",   bus.RLAST,   1'b0);
    rst_n = 1'b1;
    step(); step();

    // ---- table-driven vectors ----
    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
      if (v.is_wr) begin
        for (int i = 0; i <= v.len; i++) begin wbuf[i] = v.data0 + i; sbuf[i] = v.strb; end
        axi_write(v.addr, v.len, v.burst, -1, resp, lat);
        chk($sformatf("v%0d_bresp", k), resp, v.exp_resp);
        chk($sformatf("v%0d_wlat", k), lat, WR_LAT);
      end else begin
        axi_read(v.addr, v.len, v.burst, -1, 0, lat);
        chk($sformatf("v%0d_rlat", k), lat, RD_LAT);
        for (int i = 0; i <= v.len; i++) begin
          chk($sformatf("v%0d_rresp%0d", k, i), rd_resp[i], v.exp_resp);
          chk($sformatf("v%0d_rlast%0d", k, i), rd_last[i], (i == v.len));
          if (i < 4 && v.exp_mask[i]) chk($sformatf("v%0d_rdata%0d", k, i), rd_data[i], v.exp_d[i]);
        end
      end
    end

    // ---- WLAST mismatch: early and missing ----
    for (int i = 0; i < 2; i++) begin wbuf[i] = 32'h0; sbuf[i] = 4'hF; end
    axi_write(32'h200, 1, 2'b01, 0, resp, lat);
    chk("wlast_early_bresp", resp, 2'b10);
    axi_write(32'h200, 1, 2'b01, 1, resp, lat);
    chk("wlast_missing_bresp", resp, 2'b10);

    // ---- RREADY stall mid-burst ----
    axi_read(32'h10, 3, 2'b01, 1, 5, lat);
    chk("stall_d0", rd_data[0], 32'hA0000002);
    chk("stall_d1", rd_data[1], 32'hA0000003);
    chk("stall_d2", rd_data[2], 32'hA0000000);
    chk("stall_d3", rd_data[3], 32'hA0000001);

    // ---- reset pulse during W_DATA ----
    if (!abort) begin
      bus.AWADDR = 32'h40; bus.AWLEN = 8'd3; bus.AWBURST = 2'b01; bus.AWVALID = 1'b1;
      step();
      bus.AWVALID = 1'b0;
      chk("mid_wready", bus.WREADY, 1'b1);
      bus.WDATA = 32'h00000077; bus.WSTRB = 4'hF; bus.WLAST = 1'b0; bus.WVALID = 1'b1;
      step();
      bus.WVALID = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_awready", bus.AWREADY, 1'b1);
      chk("mid_rst_wready",  bus.WREADY,  1'b0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_awready", bus.AWREADY, 1'b1);
      axi_read(32'h40, 0, 2'b01, -1, 0, lat);
      chk("post_rst_kept_word", rd_data[0], 32'h00000077);
      wbuf[0] = 32'h12340044; wbuf[1] = 32'h12340048; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
      axi_write(32'h44, 1, 2'b01, -1, resp, lat);
      chk("post_rst_bresp", resp, 2'b00);
      axi_read(32'h44, 1, 2'b01, -1, 0, lat);
      chk("post_rst_rd0", rd_data[0], 32'h12340044);
      chk("post_rst_rd1", rd_data[1], 32'h12340048);
    end

    // ---- randomized phase against the reference model ----
    for (int i = 0; i < 128; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    axi_write(32'h0, 127, 2'b01, -1, resp, lat);
    model_write(32'h0, 127, 2'b01);
    chk("init_a_bresp", resp, 2'b00);
    for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    axi_write(32'hFFC0, 15, 2'b01, -1, resp, lat);
    model_write(32'hFFC0, 15, 2'b01);
    chk("init_b_bresp", resp, 2'b00);

    for (int t = 0; t < 80 && !abort; t++) begin
      if ($urandom_range(0, 3) == 0) addr = 32'hFFC0 + $urandom_range(0, 127);
      else                           addr = $urandom_range(0, 255);
      r = $urandom_range(0, 9);
      if (r < 5)      burst = 2'b01;
      else if (r < 9) burst = 2'b10;
      else            burst = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
      if (burst == 2'b10 && $urandom_range(0, 4) != 0) begin
        r = $urandom_range(0, 3);
        len = (r == 0) ? 1 : (r == 1) ? 3 : (r == 2) ? 7 : 15;
      end else begin
        len = $urandom_range(0, 15);
      end
      err = model_err(longint'(addr), len, burst);
      if ($urandom_range(0, 1) != 0) begin
        for (int i = 0; i <= len; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom_range(0, 15)); end
        axi_write(addr, len, burst, -1, resp, lat);
        model_write(addr, len, burst);
        chk($sformatf("rnd%0d_bresp", t), resp, err ? 2'b10 : 2'b00);
        chk($sformatf("rnd%0d_wlat", t), lat, WR_LAT);
      end else begin
        model_read(addr, len, burst);
        axi_read(addr, len, burst, $urandom_range(0, len + 2), $urandom_range(0, 3), lat);
        chk($sformatf("rnd%0d_rlat", t), lat, RD_LAT);
        for (int i = 0; i <= len; i++) begin
          chk($sformatf("rnd%0d_rdata%0d", t, i), rd_data[i], exp_q.pop_front());
          chk($sformatf("rnd%0d_rresp%0d", t, i), rd_resp[i], err ? 2'b10 : 2'b00);
          chk($sformatf("rnd%0d_rlast%0d", t, i), rd_last[i], (i == len));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the bench itself wedges.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
